// File: rtl/seq_divider.sv
// Multicycle 32-bit restoring divider (DIV/DIVU). It does all subtraction and negation
// on an external shared carry-in adder and registers results behind a start/busy/done handshake.
module seq_divider #(
  parameter logic [31:0] DBZ_QUOTIENT = 32'hFFFF_FFFF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_is_signed,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_quotient,
  output logic [31:0] o_remainder,
  output logic [31:0] o_add_a,
  output logic [31:0] o_add_b,
  output logic        o_add_c0,
  input  logic [32:0] i_add_s
);

  typedef enum logic [2:0] {StIdle, StAbsA, StAbsB, StDiv, StFixQ, StFixR, StDone} state_e;

  state_e      r_state;
  logic [31:0] r_q, r_r, r_d;
  logic [4:0]  r_cnt;
  logic        r_neg_q, r_neg_r, r_neg_d;
  logic        r_busy, r_done;
  logic [31:0] r_quotient, r_remainder;

  logic [31:0] w_rs;
  logic        w_ge;

  // The shifted-out top bit of R means Rs >= 2^32 > D, so subtract regardless of carry.
  assign w_rs = {r_r[30:0], r_q[31]};
  assign w_ge = r_r[31] | i_add_s[32];

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_quotient  = r_quotient;
  assign o_remainder = r_remainder;

  always_comb begin
    o_add_a  = '0;
    o_add_b  = '0;
    o_add_c0 = 1'b0;
    case (r_state)
      StAbsA: begin
        o_add_a  = r_neg_r ? ~r_q : r_q;
        o_add_c0 = r_neg_r;
      end
      StAbsB: begin
        o_add_a  = r_neg_d ? ~r_d : r_d;
        o_add_c0 = r_neg_d;
      end
      StDiv: begin
        o_add_a  = w_rs;
        o_add_b  = ~r_d;
        o_add_c0 = 1'b1;
      end
      StFixQ: begin
        o_add_a  = r_neg_q ? ~r_q : r_q;
        o_add_c0 = r_neg_q;
      end
      StFixR: begin
        o_add_a  = r_neg_r ? ~r_r : r_r;
        o_add_c0 = r_neg_r;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_q         <= '0;
      r_r         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_neg_d     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      case (r_state)
        StIdle, StDone: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
          if (i_start) begin
            r_q     <= i_dividend;
            r_d     <= i_divisor;
            r_neg_r <= i_is_signed & i_dividend[31];
            r_neg_d <= i_is_signed & i_divisor[31];
            r_neg_q <= i_is_signed & (i_dividend[31] ^ i_divisor[31]);
            if (i_divisor == 32'd0) begin
              r_quotient  <= DBZ_QUOTIENT;
              r_remainder <= i_dividend;
              r_done      <= 1'b1;
              r_state     <= StDone;
            end else begin
              r_busy  <= 1'b1;
              r_state <= StAbsA;
            end
          end else begin
            r_state <= StIdle;
          end
        end
        StAbsA: begin
          r_q     <= i_add_s[31:0];
          r_r     <= '0;
          r_state <= StAbsB;
        end
        StAbsB: begin
          r_d     <= i_add_s[31:0];
          r_cnt   <= '0;
          r_state <= StDiv;
        end
        StDiv: begin
          r_r   <= w_ge ? i_add_s[31:0] : w_rs;
          r_q   <= {r_q[30:0], w_ge};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= StFixQ;
        end
        StFixQ: begin
          r_quotient <= i_add_s[31:0];
          r_state    <= StFixR;
        end
        StFixR: begin
          r_remainder <= i_add_s[31:0];
          r_busy      <= 1'b0;
          r_done      <= 1'b1;
          r_state     <= StDone;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: models the shared adder, keeps an arithmetic reference model of the
// handshake and results, and checks directed divisions against hand-computed values.
module tb_seq_divider;

  localparam logic [31:0] DBZ = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend, divisor;
  logic        busy, done;
  logic [31:0] quotient, remainder;
  logic [31:0] add_a, add_b;
  logic        add_c0;
  logic [32:0] add_s;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  assign add_s = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_c0};

  seq_divider #(.DBZ_QUOTIENT(DBZ)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_is_signed (is_signed),
    .i_dividend  (dividend),
    .i_divisor   (divisor),
    .o_busy      (busy),
    .o_done      (done),
    .o_quotient  (quotient),
    .o_remainder (remainder),
    .o_add_a     (add_a),
    .o_add_b     (add_b),
    .o_add_c0    (add_c0),
    .i_add_s     (add_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: {quotient, remainder} from magnitudes, truncating toward zero.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    ma = (s && a[31]) ? -a : a;
    mb = (s && b[31]) ? -b : b;
    q  = ma / mb;
    r  = ma % mb;
    if (s && (a[31] ^ b[31])) q = -q;
    if (s && a[31]) r = -r;
    return {q, r};
  endfunction

  // Model: cycles of busy remaining, done pulse, and result registers.
  int          m_cnt = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_q = '0, m_r = '0;
  logic [63:0] m_pend = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
    end else if (m_cnt == 0 && start) begin
      if (divisor == 32'd0) begin
        m_q    <= DBZ;
        m_r    <= dividend;
        m_done <= 1'b1;
      end else begin
        m_pend <= ref_div(is_signed, dividend, divisor);
        m_cnt  <= 36;
        m_done <= 1'b0;
      end
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_done <= 1'b1;
        m_q    <= m_pend[63:32];
        m_r    <= m_pend[31:0];
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'd0, busy}, {31'd0, (m_cnt > 0)});
      check("done", {31'd0, done}, {31'd0, m_done});
      if (m_cnt == 0) begin
        check("quotient_model", quotient, m_q);
        check("remainder_model", remainder, m_r);
        check("adder_idle", add_a | add_b | {31'd0, add_c0}, 32'd0);
      end
    end
  end

  // Called at a negedge; raises start immediately (so back-to-back calls start in DONE).
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input int lat,
                        input int inj);
    int c;
    start     = 1'b1;
    is_signed = s;
    dividend  = a;
    divisor   = b;
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    c = 1;
    while (!done && c < 60) begin
      if (c == inj) begin
        start     = 1'b1;
        is_signed = 1'b1;
        dividend  = 32'd9;
        divisor   = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    check("latency", c, lat);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_quotient", quotient, 32'd0);
    check("reset_remainder", remainder, 32'd0);
    @(negedge clk);

    run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 37, 0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 37, 0);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 37, 0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 37, 0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 37, 0);
    run_op(1'b0, 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1, 0);
    repeat (3) @(negedge clk);
    run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 37, 10);
    run_op(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 37, 0);
    run_op(1'b1, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 1, 0);
    repeat (2) @(negedge clk);

    // Reset in the middle of an operation.
    start     = 1'b1;
    is_signed = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_quotient", quotient, 32'd0);
    check("midrst_remainder", remainder, 32'd0);
    run_op(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 37, 0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multicycle 32-bit restoring divider for the CPU's DIV/DIVU path.
- Sits directly upstream of the shared 32-bit carry-in adder: it drives that adder's operands and carry-in, and consumes its 33-bit sum.
- Performs all subtraction and negation through the adder (A + ~B + 1); it has no internal 32-bit adder.
- Results are registered with a start/busy/done handshake.

Parameters:
- DBZ_QUOTIENT, 32'hFFFF_FFFF, quotient returned on divide-by-zero.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; latched with start
- dividend  input  32  latched with start
- divisor  input  32  latched with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; results valid from this cycle onward
- quotient  output  32  registered; held until next accepted start
- remainder  output  32  registered; held until next accepted start
- add_a  output  32  adder operand A (combinational from state/registers)
- add_b  output  32  adder operand B
- add_c0  output  1  adder carry-in
- add_s  input  33  adder sum {carry_out, sum}; used in the same cycle

Behaviour:
- One clock, clk. Reset is synchronous and active-high (rst).
- Reset, including mid-operation: state IDLE; busy=0, done=0, quotient=0, remainder=0, add_a/add_b/add_c0=0. Any operation in flight is abandoned.
- States: IDLE, ABS_A, ABS_B, DIV, FIX_Q, FIX_R, DONE.
- IDLE/DONE with start=1:
  - Latch the operands and is_signed.
  - If divisor==0: next state DONE; quotient=DBZ_QUOTIENT; remainder=dividend.
  - Otherwise: next state ABS_A.
- start in any other state is ignored.
- DONE: done=1 for exactly one cycle, then IDLE unless start is accepted in that cycle.
- busy=1 in ABS_A, ABS_B, DIV, FIX_Q, FIX_R; 0 in IDLE and DONE.
- ABS_A:
  - If is_signed and dividend[31]: add_a=~dividend, add_b=0, add_c0=1.
  - Else: add_a=dividend, add_b=0, add_c0=0.
  - Register add_s[31:0] as |dividend| into the Q shift register; clear R (32b).
- ABS_B: same rule applied to divisor; register |divisor| into D.
- Record the sign flags: neg_q = is_signed & (dividend[31] ^ divisor[31]); neg_r = is_signed & dividend[31].
- DIV: exactly 32 iterations, with a 5-bit counter 0..31.
  - Shift: {msb, Rs} = {R, Q[31]}, a 33-bit shifted partial remainder.
  - Adder: add_a=Rs, add_b=~D, add_c0=1.
  - ge = msb | add_s[32]. msb=1 means Rs≥2^32>D, so subtract regardless of carry.
  - If ge: R←add_s[31:0]. Else: R←Rs.
  - Q←{Q[30:0], ge}.
  - Count 31 → FIX_Q.
- FIX_Q:
  - If neg_q: adder negates Q (~Q + 0 + 1).
  - Else: passes Q through (Q + 0, c0=0).
  - quotient←add_s[31:0].
- FIX_R: same as FIX_Q, using R and neg_r; remainder←add_s[31:0]; next state DONE.
- Sign rules: quotient truncates toward zero; remainder takes the dividend's sign.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed): quotient=0x80000000, remainder=0, with no special casing.
- Latency (nonzero divisor): done is high exactly 37 cycles after the start-sampling edge. This is fixed and independent of operand values.
- Latency (divisor 0): done is high on the cycle after start is sampled.
- IDLE/DONE: add_a/add_b/add_c0=0; add_s is ignored.
- quotient/remainder update only in FIX_Q/FIX_R or on a divide-by-zero start. They are stable otherwise, including across ignored starts.

Test Plan:
- DIVU 100/7 -> done at cycle 37, quotient=14, remainder=2; busy high for cycles 1..36.
- DIV 0xFFFFFFF9(-7)/2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. DIV 7/0xFFFFFFFE -> quotient=0xFFFFFFFD, remainder=1.
- DIVU 0xFFFFFFFF/0x80000001 (exercises msb path) -> quotient=1, remainder=0x7FFFFFFE. DIV 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
- DIVU 1234/0 -> done on next cycle, quotient=0xFFFFFFFF, remainder=1234, busy never high.
- start pulsed at cycle 10 during a 100/7 operation with other operands -> ignored; result still 14/2 at cycle 37. start asserted in the DONE cycle -> accepted; next result correct.
- rst asserted at cycle 20 of an operation -> next cycle busy=0, done=0, quotient=remainder=0; a new 50/5 completes normally with quotient=10, remainder=0.
